jtcps2_obj_draw: RTL and testbench

Object tile renderer for the CPS2 sprite pipeline: the consumer of the object scanner's draw handshake. Accepts one 16-pixel-wide tile row per `start` pulse, fetches two 32-bit planar words from object ROM, and writes 16 pixels into the object line buffer at the requested horizontal position. Colour 15 pixels are skipped. `idle` is held low while a tile is in progress.

---
 rtl/jtcps2_obj_draw.sv | 149 ++++++++++++++
 tb/tb_jtcps2_obj_draw.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcps2_obj_draw.sv
// CPS2 object tile renderer: fetches two planar ROM words per 16-pixel tile row and writes the
// non-transparent pixels to the line buffer. Optional `JTCPS2_OBJDRAW_PREFETCH_EN overlaps the second fetch with drawing.
module jtcps2_obj_draw (
    input  logic        rst,
    input  logic        clk,
    input  logic        start,
    output logic        idle,
    input  logic [15:0] code,
    input  logic [15:0] attr,
    input  logic [8:0]  hpos,
    input  logic [2:0]  prio,
    input  logic [1:0]  bank,
    output logic [22:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic [8:0]  buf_addr,
    output logic [11:0] buf_data,
    output logic        buf_wr
);

    typedef enum logic [2:0] {IDLE, REQ0, DRAW0, REQ1, DRAW1} state_t;

    state_t      state, state_nxt;
    logic [15:0] code_r;
    logic [3:0]  vsub_r;
    logic        hflip_r;
    logic [4:0]  pal_r;
    logic [2:0]  prio_r;
    logic [1:0]  bank_r;
    logic [8:0]  x_r;
    logic [31:0] sr;
    logic [2:0]  cnt;
    logic        fresh;
    logic        take;
    logic        half_sel;
    logic [3:0]  pixel;
    logic        unused_attr;

    assign unused_attr = ^{attr[15:12], attr[7:6]};

    // rom_ok is not trusted in the first cycle after the address moves
    assign take = rom_ok && !fresh;

`ifdef JTCPS2_OBJDRAW_PREFETCH_EN
    logic [31:0] hold;
    logic        hold_vld;
    logic        pf_take;
    assign pf_take = (state == DRAW0) && !hold_vld && take;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = REQ0;
            REQ0:  if (take) state_nxt = DRAW0;
            DRAW0: if (cnt == 3'd7) begin
`ifdef JTCPS2_OBJDRAW_PREFETCH_EN
                       state_nxt = (hold_vld || pf_take) ? DRAW1 : REQ1;
`else
                       state_nxt = REQ1;
`endif
                   end
            REQ1:  if (take) state_nxt = DRAW1;
            DRAW1: if (cnt == 3'd7) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r  <= 16'd0;
            vsub_r  <= 4'd0;
            hflip_r <= 1'b0;
            pal_r   <= 5'd0;
            prio_r  <= 3'd0;
            bank_r  <= 2'd0;
            x_r     <= 9'd0;
            sr      <= 32'd0;
            cnt     <= 3'd0;
            fresh   <= 1'b0;
        end else begin
`ifdef JTCPS2_OBJDRAW_PREFETCH_EN
            fresh <= (state_nxt != state) &&
                     (state_nxt == REQ0 || state_nxt == REQ1 || state_nxt == DRAW0);
`else
            fresh <= (state_nxt != state) && (state_nxt == REQ0 || state_nxt == REQ1);
`endif
            if (state == IDLE && start) begin
                code_r  <= code;
                vsub_r  <= attr[11:8];
                hflip_r <= attr[5];
                pal_r   <= attr[4:0];
                prio_r  <= prio;
                bank_r  <= bank;
                x_r     <= hpos;
            end
            if ((state == REQ0 || state == REQ1) && take) begin
                sr  <= rom_data;
                cnt <= 3'd0;
            end
            if (state == DRAW0 || state == DRAW1) begin
                cnt <= cnt + 3'd1;
                x_r <= x_r + 9'd1;
                sr  <= hflip_r ? (sr >> 1) : (sr << 1);
`ifdef JTCPS2_OBJDRAW_PREFETCH_EN
                if (state == DRAW0 && cnt == 3'd7 && (hold_vld || pf_take))
                    sr <= hold_vld ? hold : rom_data;
`endif
            end
        end
    end

`ifdef JTCPS2_OBJDRAW_PREFETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= 32'd0;
            hold_vld <= 1'b0;
        end else if (state == IDLE && start) begin
            hold_vld <= 1'b0;
        end else if (pf_take) begin
            hold     <= rom_data;
            hold_vld <= 1'b1;
        end
    end
`endif

    always_comb begin
        idle     = (state == IDLE);
`ifdef JTCPS2_OBJDRAW_PREFETCH_EN
        rom_cs   = (state == REQ0) || (state == REQ1) || (state == DRAW0 && !hold_vld);
        half_sel = (state == REQ1) || (state == DRAW1) || (state == DRAW0);
`else
        rom_cs   = (state == REQ0) || (state == REQ1);
        half_sel = (state == REQ1) || (state == DRAW1);
`endif
        rom_addr = {bank_r, code_r, vsub_r, hflip_r ^ half_sel};
        pixel    = hflip_r ? {sr[24], sr[16], sr[8], sr[0]} : {sr[31], sr[23], sr[15], sr[7]};
        buf_wr   = (state == DRAW0 || state == DRAW1) && (pixel != 4'hF);
        buf_addr = x_r;
        buf_data = {prio_r, pal_r, pixel};
    end

endmodule

// File: tb/tb_jtcps2_obj_draw.sv
// Scoreboard bench for jtcps2_obj_draw: a ROM responder with random wait states, a reference
// model that predicts ROM requests and line-buffer writes per tile, and negedge monitors.
module tb_jtcps2_obj_draw;

    logic        rst = 1'b1;
    logic        clk = 1'b0;
    logic        start = 1'b0;
    logic        idle;
    logic [15:0] code = 16'd0;
    logic [15:0] attr = 16'd0;
    logic [8:0]  hpos = 9'd0;
    logic [2:0]  prio = 3'd0;
    logic [1:0]  bank = 2'd0;
    logic [22:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok = 1'b0;
    logic [31:0] rom_data = 32'd0;
    logic [8:0]  buf_addr;
    logic [11:0] buf_data;
    logic        buf_wr;

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    int rom_mode = 0;
    logic [31:0] rom_word = 32'd0;
    int force_wait = -1;

    logic [20:0] exp_wr[$];
    logic [22:0] exp_addr[$];

`ifdef JTCPS2_OBJDRAW_PREFETCH_EN
    localparam int EXP_LAT = 18;
`else
    localparam int EXP_LAT = 20;
`endif

    jtcps2_obj_draw dut (
        .rst(rst), .clk(clk), .start(start), .idle(idle),
        .code(code), .attr(attr), .hpos(hpos), .prio(prio), .bank(bank),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_wr(buf_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [22:0] a);
        logic [31:0] h;
        if (rom_mode == 1) return 32'hFFFF_FFFF;
        if (rom_mode == 2) return rom_word;
        h = {9'd0, a} * 32'h9E37_79B1;
        h = h ^ (h >> 13) ^ 32'h5A5A_0F0F;
        return h;
    endfunction

    // ROM model: garbage data while the address is fresh, correct data afterwards
    int          rsp_cnt = 0;
    int          rsp_wait = 0;
    logic        rsp_cs_q = 1'b0;
    logic [22:0] rsp_addr_q = 23'd0;
    always @(negedge clk) begin
        if (rst) begin
            rom_ok  = 1'b0;
            rsp_cnt = 0;
        end else if (rom_cs) begin
            if (!rsp_cs_q || rom_addr != rsp_addr_q) begin
                rsp_cnt  = 0;
                rsp_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            end else begin
                rsp_cnt++;
            end
            rom_ok   = (rsp_cnt >= rsp_wait);
            rom_data = (rsp_cnt == 0) ? ~rom_fn(rom_addr) : rom_fn(rom_addr);
        end else begin
            rom_ok   = 1'b0;
            rom_data = $urandom;
        end
        rsp_cs_q   = rom_cs && !rst;
        rsp_addr_q = rom_addr;
    end

    logic        am_cs_q = 1'b0;
    logic [22:0] am_addr_q = 23'd0;
    always @(negedge clk) begin
        logic [22:0] e;
        if (!rst) begin
            if (rom_cs && (!am_cs_q || rom_addr != am_addr_q)) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL rom_req unexpected got=%h", rom_addr);
                end else begin
                    e = exp_addr.pop_front();
                    if (e !== rom_addr) begin
                        errors++;
                        $display("FAIL rom_addr got=%h exp=%h", rom_addr, e);
                    end
                end
            end
            am_cs_q   = rom_cs;
            am_addr_q = rom_addr;
        end else begin
            am_cs_q = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst && buf_wr) begin
            wr_seen++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL buf_write unexpected got addr=%0d data=%h", buf_addr, buf_data);
            end else begin
                e = exp_wr.pop_front();
                if (e !== {buf_addr, buf_data}) begin
                    errors++;
                    $display("FAIL buf_write got addr=%0d data=%h exp addr=%0d data=%h",
                             buf_addr, buf_data, e[20:12], e[11:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (!idle && n < budget) begin
            tick();
            n++;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy after %0d cycles exp=idle", n);
        end
    endtask

    task automatic issue(input logic [15:0] c, input logic [15:0] a, input logic [8:0] hp,
                         input logic [2:0] p, input logic [1:0] b);
        int          n;
        logic [22:0] ad;
        logic [31:0] w;
        logic [3:0]  px;
        logic [8:0]  x;
        wait_idle(300, n);
        for (int j = 0; j < 2; j++) begin
            ad = {b, c, a[11:8], a[5] ^ j[0]};
            exp_addr.push_back(ad);
            w = rom_fn(ad);
            for (int i = 0; i < 8; i++) begin
                px = a[5] ? {w[24+i], w[16+i], w[8+i], w[i]}
                          : {w[31-i], w[23-i], w[15-i], w[7-i]};
                x  = hp + 9'(8 * j + i);
                if (px != 4'hF) exp_wr.push_back({x, p, a[4:0], px});
            end
        end
        code = c; attr = a; hpos = hp; prio = p; bank = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        code = $urandom; attr = $urandom; hpos = $urandom; prio = $urandom; bank = $urandom;
    endtask

    initial begin
        int n;
        int w0;
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        repeat (3) tick();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_rom_cs", 32'(rom_cs), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_buf_wr", 32'(buf_wr), 32'd0);
        chk("rst_buf_addr", 32'(buf_addr), 32'd0);
        chk("rst_buf_data", 32'(buf_data), 32'd0);
        rst = 1'b0;
        tick();

        // zero-wait tile, latency to idle
        force_wait = 0;
        issue(16'h0123, {4'h0, 4'd5, 2'b00, 1'b0, 5'd7}, 9'd40, 3'd3, 2'd2);
        wait_idle(100, n);
        chk("idle_latency", 32'(n), 32'(EXP_LAT));

        // fully transparent tile
        rom_mode = 1;
        w0 = wr_seen;
        issue($urandom, $urandom, $urandom, $urandom, $urandom);
        wait_idle(100, n);
        repeat (2) tick();
        chk("transparent_writes", 32'(wr_seen - w0), 32'd0);

        // hflip with a single set bit at each end of the word
        rom_mode = 2;
        rom_word = 32'h8000_0001;
        issue(16'h4321, {4'h0, 4'd9, 2'b00, 1'b1, 5'd19}, 9'd100, 3'd5, 2'd1);
        wait_idle(100, n);

        // x wraps from 511 to 0
        rom_word = 32'h0000_0000;
        w0 = wr_seen;
        issue(16'h0777, {4'h0, 4'd2, 2'b00, 1'b0, 5'd3}, 9'd508, 3'd1, 2'd3);
        wait_idle(100, n);
        repeat (2) tick();
        chk("wrap_writes", 32'(wr_seen - w0), 32'd16);
        rom_mode = 0;

        // start pulse in mid-draw is ignored
        issue(16'h1111, 16'h0A2C, 9'd200, 3'd2, 2'd0);
        repeat (4) tick();
        chk("mid_draw_busy", 32'(idle), 32'd0);
        code = 16'hBEEF; attr = 16'h0F3F; hpos = 9'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(100, n);
        repeat (6) tick();
        chk("mid_draw_no_second", 32'(idle), 32'd1);
        chk("mid_draw_addr_drained", 32'(exp_addr.size()), 32'd0);

        // ROM stall, then reset while drawing
        force_wait = 10;
        issue(16'h2222, 16'h0315, 9'd300, 3'd6, 2'd1);
        n = 0;
        while (!buf_wr && n < 100) begin
            tick();
            n++;
        end
        chk("stall_draw_reached", 32'(n > 10), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        exp_wr.delete();
        exp_addr.delete();
        #1;
        chk("arst_idle", 32'(idle), 32'd1);
        chk("arst_rom_cs", 32'(rom_cs), 32'd0);
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_buf_wr", 32'(buf_wr), 32'd0);
        chk("arst_buf_addr", 32'(buf_addr), 32'd0);
        chk("arst_buf_data", 32'(buf_data), 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("arst_not_resumed", 32'(idle), 32'd1);
        force_wait = -1;
        issue(16'h3333, 16'h0204, 9'd12, 3'd4, 2'd2);
        chk("post_reset_accept", 32'(idle), 32'd0);
        wait_idle(100, n);

        // random back-to-back tiles with random ROM waits
        for (int t = 0; t < 40; t++)
            issue($urandom, $urandom, $urandom, $urandom, $urandom);
        wait_idle(300, n);
        repeat (5) tick();
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
